// File: rtl/reply_cnt_check.sv
`default_nettype none
// ============================================================================
// Module   : reply_cnt_check
// Brief    : Count-reply self-test master: sends request byte N over UART TX,
//            then checks that bytes 0..E-1 come back on UART RX in order.
//            Optional `ERR_CAPTURE_EN adds err_index/err_byte capture ports.
// Revision : 1.0 - initial release
// ============================================================================
module reply_cnt_check #(
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    input  logic [7:0] req_count,
    output logic       done,
    output logic       pass,
    output logic       err_mismatch,
    output logic       err_timeout,
    output logic [7:0] rx_cnt,
    input  logic       tx_done,
    input  logic       tx_active,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       rx_ready,
    input  logic [7:0] rx_data
`ifdef ERR_CAPTURE_EN
    ,
    output logic [7:0] err_index,
    output logic [7:0] err_byte
`endif
);

    localparam logic [TO_W-1:0] c_TO_LAST = TIMEOUT_CYCLES - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_req;
    logic [7:0]      r_exp;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_rx_ready_q;
    logic            r_tx_sent;
    logic            w_byte_edge;
    logic            w_unused;

    assign w_byte_edge = rx_ready & ~r_rx_ready_q;
    assign w_unused    = tx_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_req        <= 8'd0;
            r_exp        <= 8'd0;
            r_to_cnt     <= '0;
            r_rx_ready_q <= 1'b0;
            r_tx_sent    <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            rx_cnt       <= 8'd0;
            tx_data      <= 8'd0;
            tx_start     <= 1'b0;
`ifdef ERR_CAPTURE_EN
            err_index    <= 8'd0;
            err_byte     <= 8'd0;
`endif
        end else begin
            r_rx_ready_q <= rx_ready;
            tx_start     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    done         <= 1'b0;
                    pass         <= 1'b0;
                    err_mismatch <= 1'b0;
                    err_timeout  <= 1'b0;
                    tx_data      <= 8'd0;
                    r_to_cnt     <= '0;
                    r_tx_sent    <= 1'b0;
                    if (activate && !rx_ready) begin
                        r_req   <= req_count;
                        r_exp   <= (req_count == 8'd0) ? 8'd1 : req_count;
                        rx_cnt  <= 8'd0;
                        r_state <= S_SEND;
`ifdef ERR_CAPTURE_EN
                        err_index <= 8'd0;
                        err_byte  <= 8'd0;
`endif
                    end
                end
                // Two-phase send keeps the tx_start pulse entirely inside SEND.
                S_SEND: begin
                    if (r_tx_sent) begin
                        r_tx_sent <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= S_RECV;
                    end else if (!tx_active) begin
                        tx_data   <= r_req;
                        tx_start  <= 1'b1;
                        r_tx_sent <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (w_byte_edge) begin
                        if (rx_data != rx_cnt) begin
                            err_mismatch <= 1'b1;
                            done         <= 1'b1;
                            pass         <= 1'b0;
                            r_state      <= S_DONE;
`ifdef ERR_CAPTURE_EN
                            err_index    <= rx_cnt;
                            err_byte     <= rx_data;
`endif
                        end else begin
                            rx_cnt   <= rx_cnt + 8'd1;
                            r_to_cnt <= '0;
                            if ((rx_cnt + 8'd1) == r_exp) begin
                                done    <= 1'b1;
                                pass    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end else if (r_to_cnt == c_TO_LAST) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!activate && !rx_ready && !tx_active) begin
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        err_mismatch <= 1'b0;
                        err_timeout  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reply_cnt_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_reply_cnt_check
// Brief    : Scoreboard bench for reply_cnt_check with a directed UART responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reply_cnt_check;

    localparam int c_TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       activate = 1'b0;
    logic [7:0] req_count = 8'd0;
    logic       done, pass, err_mismatch, err_timeout, tx_start;
    logic [7:0] rx_cnt, tx_data;
    logic       tx_done = 1'b0;
    logic       tx_active = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'd0;
`ifdef ERR_CAPTURE_EN
    logic [7:0] err_index, err_byte;
`endif

    always #5 clk = ~clk;

    reply_cnt_check #(.TO_W(24), .TIMEOUT_CYCLES(24'(c_TO))) dut (
        .clk(clk), .reset(reset), .activate(activate), .req_count(req_count),
        .done(done), .pass(pass), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
        .rx_cnt(rx_cnt), .tx_done(tx_done), .tx_active(tx_active), .tx_data(tx_data),
        .tx_start(tx_start), .rx_ready(rx_ready), .rx_data(rx_data)
`ifdef ERR_CAPTURE_EN
        , .err_index(err_index), .err_byte(err_byte)
`endif
    );

    typedef struct {
        logic       pass;
        logic       mm;
        logic       to;
        logic [7:0] cnt;
        bit         use_cyc;
        logic [7:0] eidx;
        logic [7:0] ebyte;
    } res_t;

    res_t       res_q[$];
    logic [7:0] tx_q[$];
    res_t       r_mon;
    logic [7:0] tx_exp;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tx_seen = 0;
    int         exp_to_cyc = 0;
    logic       prev_done = 1'b0;
    logic       prev_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic res_t mk(input logic p, input logic m, input logic t, input logic [7:0] c,
                                input bit uc, input logic [7:0] ei, input logic [7:0] eb);
        res_t r;
        r.pass = p; r.mm = m; r.to = t; r.cnt = c; r.use_cyc = uc; r.eidx = ei; r.ebyte = eb;
        return r;
    endfunction

    // Monitor: pops the scoreboard on every tx_start pulse and every rising done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                tx_seen++;
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected got tx_data=%02h expected no tx_start", tx_data);
                end else begin
                    tx_exp = tx_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(tx_exp));
                end
                if (prev_start === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL tx_start_width got=2+ cycles expected=1");
                end
            end
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected got done=1 expected none");
                end else begin
                    r_mon = res_q.pop_front();
                    check("result{pass,mm,to,cnt}", {21'd0, pass, err_mismatch, err_timeout, rx_cnt},
                          {21'd0, r_mon.pass, r_mon.mm, r_mon.to, r_mon.cnt});
                    if (r_mon.use_cyc) check("timeout_cycle", 32'(cyc), 32'(exp_to_cyc));
`ifdef ERR_CAPTURE_EN
                    check("err_capture", {16'd0, err_index, err_byte}, {16'd0, r_mon.eidx, r_mon.ebyte});
`endif
                end
            end
            prev_done  = done;
            prev_start = tx_start;
        end
    end

    task automatic wait_tx(input int base);
        int t = 0;
        while (tx_seen == base && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_seen", 32'(tx_seen != base), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int hold, output int ecyc);
        @(negedge clk);
        rx_data  = v;
        rx_ready = 1'b1;
        ecyc     = cyc + 1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_run();
        int t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 32'(done), 32'd1);
        activate = 1'b0;
        t = 0;
        while (done !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("done_cleared", 32'(done), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_run(input logic [7:0] n, input int nbytes, input int bad_at,
                          input logic [7:0] bad_val, input int hold0, input int busy, input bit mark_to);
        int base;
        int ecyc;
        base = tx_seen;
        @(negedge clk);
        if (busy > 0) tx_active = 1'b1;
        req_count = n;
        activate  = 1'b1;
        if (busy > 0) begin
            repeat (busy) @(negedge clk);
            check("tx_held_off", 32'(tx_seen), 32'(base));
            tx_active = 1'b0;
        end
        wait_tx(base);
        for (int i = 0; i < nbytes; i++) begin
            send_byte((i == bad_at) ? bad_val : 8'(i), (i == 0) ? hold0 : 1, ecyc);
            if (mark_to && i == 0) exp_to_cyc = ecyc + c_TO;
        end
        finish_run();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ecyc;
        repeat (3) @(negedge clk);
        check("rst_flags", {27'd0, done, pass, err_mismatch, err_timeout, tx_start}, 32'd0);
        check("rst_cnt_data", {16'd0, rx_cnt, tx_data}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        tx_q.push_back(8'h05); res_q.push_back(mk(1, 0, 0, 8'd5, 0, 8'd0, 8'd0));
        do_run(8'd5, 5, -1, 8'd0, 1, 0, 0);

        tx_q.push_back(8'h00); res_q.push_back(mk(1, 0, 0, 8'd1, 0, 8'd0, 8'd0));
        do_run(8'd0, 1, -1, 8'd0, 1, 0, 0);

        tx_q.push_back(8'h04); res_q.push_back(mk(0, 1, 0, 8'd2, 0, 8'd2, 8'h07));
        do_run(8'd4, 3, 2, 8'h07, 1, 0, 0);

        tx_q.push_back(8'h03); res_q.push_back(mk(0, 0, 1, 8'd1, 1, 8'd0, 8'd0));
        do_run(8'd3, 1, -1, 8'd0, 1, 0, 1);

        tx_q.push_back(8'h02); res_q.push_back(mk(1, 0, 0, 8'd2, 0, 8'd0, 8'd0));
        do_run(8'd2, 2, -1, 8'd0, 10, 50, 0);

        // Abort mid-receive, then rerun with activate still held.
        tx_q.push_back(8'h04);
        base = tx_seen;
        @(negedge clk);
        req_count = 8'd4;
        activate  = 1'b1;
        wait_tx(base);
        send_byte(8'h00, 1, ecyc);
        send_byte(8'h01, 1, ecyc);
        check("pre_rst_cnt", 32'(rx_cnt), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_flags", {27'd0, done, pass, err_mismatch, err_timeout, tx_start}, 32'd0);
        check("mid_rst_cnt_data", {16'd0, rx_cnt, tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        tx_q.push_back(8'h04); res_q.push_back(mk(1, 0, 0, 8'd4, 0, 8'd0, 8'd0));
        base  = tx_seen;
        reset = 1'b1;
        wait_tx(base);
        for (int i = 0; i < 4; i++) send_byte(8'(i), 1, ecyc);
        finish_run();

        repeat (5) @(negedge clk);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
